sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single-port user SRAM (512 x 32, 1-cycle read latency) between three requesters:
  - the Wishbone management loader (WB)
  - the Elpis core data port (DM)
  - the Elpis core instruction-fetch port (IF)
- Sits in the user project wrapper between `custom_sram` and `core0` / the Wishbone slave.
- Grants at most one access per cycle and routes read data back to the requester that issued the read.
- Provides starvation protection so the core keeps progressing while the management SoC streams data.

Parameters:
- ADDR_W, 9, SRAM word-address width.
- DATA_W, 32, data width; the byte mask is DATA_W/8 bits.
- STARVE_MAX, 8, number of consecutive WB grants with a core request pending before one core grant is forced (range 1..255).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_req_i  in  1  WB access request; held until granted.
- wbs_we_i  in  1  WB write enable.
- wbs_addr_i  in  ADDR_W  WB word address.
- wbs_wdata_i  in  DATA_W  WB write data.
- wbs_wmask_i  in  DATA_W/8  WB byte mask.
- wbs_gnt_o  out  1  WB access accepted this cycle.
- wbs_rvalid_o  out  1  WB read data valid.
- wbs_rdata_o  out  DATA_W  WB read data.
- dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_wmask_i, dm_gnt_o, dm_rvalid_o, dm_rdata_o: same as the WB set, for the core data port.
- if_req_i  in  1  fetch request (read only).
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch accepted.
- if_rvalid_o  out  1  instruction valid.
- if_rdata_o  out  DATA_W  instruction.
- sram_csb_o  out  1  SRAM chip select, active low.
- sram_web_o  out  1  SRAM write enable, active low.
- sram_wmask_o  out  DATA_W/8  SRAM byte mask.
- sram_addr_o  out  ADDR_W  SRAM address.
- sram_din_o  out  DATA_W  SRAM write data.
- sram_dout_i  in  DATA_W  SRAM read data, valid the cycle after a read.

Behaviour:
- Reset values:
  - All *_gnt_o and *_rvalid_o are 0.
  - sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, sram_addr_o=0, sram_din_o=0.
  - starve_cnt=0, rr_last=IF (so DM wins the first core tie), rd_owner=NONE.
- Grant timing:
  - Grant is combinational in the request cycle.
  - The SRAM control outputs for the granted access are driven in that same cycle; exactly one gnt is high.
  - Requester inputs must be stable while req is high and gnt is low.
- Arbitration, per cycle:
  - The WB request wins, unless starve_cnt==STARVE_MAX and (dm_req_i or if_req_i).
  - Otherwise a core port wins. DM and IF are round-robin; the port that was not granted last wins a tie, and a lone requester always wins.
  - No requests: sram_csb_o=1 and no gnt.
- Starvation counter:
  - Increments on a WB grant while a core request is pending, saturating at STARVE_MAX.
  - Clears on any core grant, and on any cycle with no core request.
- Reads:
  - A granted read with we=0 sets rd_owner to the requester.
  - The next cycle, that requester's rvalid_o=1 and its rdata_o=sram_dout_i.
  - rdata_o of non-owners is 0.
  - Back-to-back reads from different owners are fully pipelined: one read result per cycle.
- Writes:
  - A granted write with we=1 drives sram_web_o=0 and sram_wmask_o=wmask.
  - No rvalid is generated.
  - wmask=0 is still granted; the SRAM contents are unchanged.
- Simultaneous events:
  - A read result returns on the same cycle as a new grant to another port; both are allowed.
  - rvalid to requester A and gnt to requester B may be high together.
- Reset mid-operation: any in-flight rvalid is dropped (rd_owner cleared), and the counters and pointer return to their reset values.
- Throughput: one SRAM access per cycle; no bubbles between grants.

Decomposition:
- Package `elpis_sram_pkg`:
  - requester id enum REQ_NONE/REQ_WB/REQ_DM/REQ_IF (2 bits)
  - default SRAM_ADDR_W=9, SRAM_DATA_W=32
  - STARVE_MAX default
- Sub-module `sram_grant_pick`: combinational priority/round-robin selection from req bits, starve flag and rr_last, producing a one-hot grant.
- The top level holds starve_cnt, rr_last, rd_owner and the SRAM mux.

Test Plan:
- IF-only read of addr 0x010 holding 0xDEADBEEF: if_gnt_o in cycle N, if_rvalid_o=1 with 0xDEADBEEF in cycle N+1; the other rvalids stay 0.
- DM and IF requesting continuously, no WB, for 6 cycles: grants alternate DM, IF, DM, IF, DM, IF.
- WB streams writes continuously while DM requests, STARVE_MAX=8:
  - WB is granted 8 cycles, then DM is granted 1 cycle, then WB resumes.
  - starve_cnt is 0 after the DM grant.
- WB write 0x12345678 mask 4'b0011 to addr 0x1FF, then a DM read of 0x1FF: SRAM sees web=0 with wmask=0011 in the write cycle; dm_rvalid_o delivers the merged word one cycle after the read grant.
- Back-to-back WB read (cycle N) then IF read (cycle N+1): wbs_rvalid_o in N+1 and if_rvalid_o in N+2, each with its own address data.
- wb_rst_i asserted the cycle after a DM read grant: dm_rvalid_o stays 0, and all outputs take their reset values at the next edge.

Source files
------------

// File: rtl/elpis_sram_pkg.sv
// Shared types and defaults for the user-SRAM port arbiter.
// Requester ids, grant bit positions and default geometry.
package elpis_sram_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_WB   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_IF   = 2'd3
  } req_id_e;

  localparam int unsigned SRAM_ADDR_W    = 9;
  localparam int unsigned SRAM_DATA_W    = 32;
  localparam int unsigned STARVE_MAX_DEF = 8;

  // Bit positions inside the one-hot grant vector.
  localparam int unsigned GNT_WB = 0;
  localparam int unsigned GNT_DM = 1;
  localparam int unsigned GNT_IF = 2;

endpackage

// File: rtl/sram_grant_pick.sv
// One-hot grant selection: WB priority unless the core is being starved,
// DM/IF share the remaining slot round-robin.
module sram_grant_pick
  import elpis_sram_pkg::*;
(
  input  logic       wb_req_i,
  input  logic       dm_req_i,
  input  logic       if_req_i,
  input  logic       starve_i,
  input  logic       rr_last_if_i,
  output logic [2:0] gnt_o
);

  logic core_req;

  assign core_req = dm_req_i | if_req_i;

  always_comb begin
    gnt_o = '0;
    if (wb_req_i && !(starve_i && core_req)) begin
      gnt_o[GNT_WB] = 1'b1;
    end else if (dm_req_i && (!if_req_i || rr_last_if_i)) begin
      gnt_o[GNT_DM] = 1'b1;
    end else if (if_req_i) begin
      gnt_o[GNT_IF] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single-port user SRAM between the Wishbone loader and the
// Elpis core data and fetch ports, routing read data back to its issuer.
module sram_port_arbiter
  import elpis_sram_pkg::*;
#(
  parameter int unsigned ADDR_W     = SRAM_ADDR_W,
  parameter int unsigned DATA_W     = SRAM_DATA_W,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,

  input  logic                wbs_req_i,
  input  logic                wbs_we_i,
  input  logic [ADDR_W-1:0]   wbs_addr_i,
  input  logic [DATA_W-1:0]   wbs_wdata_i,
  input  logic [DATA_W/8-1:0] wbs_wmask_i,
  output logic                wbs_gnt_o,
  output logic                wbs_rvalid_o,
  output logic [DATA_W-1:0]   wbs_rdata_o,

  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_wmask_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,

  output logic                sram_csb_o,
  output logic                sram_web_o,
  output logic [DATA_W/8-1:0] sram_wmask_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_din_o,
  input  logic [DATA_W-1:0]   sram_dout_i
);

  logic [7:0] starve_cnt;
  logic       rr_last_if;
  req_id_e    rd_owner;

  logic       wb_req, dm_req, if_req, core_req, starve;
  logic [2:0] gnt;

  // Requests are masked during reset so every output sits at its reset value.
  assign wb_req   = wbs_req_i & ~wb_rst_i;
  assign dm_req   = dm_req_i & ~wb_rst_i;
  assign if_req   = if_req_i & ~wb_rst_i;
  assign core_req = dm_req | if_req;
  assign starve   = (starve_cnt == 8'(STARVE_MAX));

  sram_grant_pick u_pick (
    .wb_req_i     (wb_req),
    .dm_req_i     (dm_req),
    .if_req_i     (if_req),
    .starve_i     (starve),
    .rr_last_if_i (rr_last_if),
    .gnt_o        (gnt)
  );

  assign wbs_gnt_o = gnt[GNT_WB];
  assign dm_gnt_o  = gnt[GNT_DM];
  assign if_gnt_o  = gnt[GNT_IF];

  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    if (gnt[GNT_WB]) begin
      sram_csb_o  = 1'b0;
      sram_web_o  = ~wbs_we_i;
      sram_addr_o = wbs_addr_i;
      if (wbs_we_i) begin
        sram_wmask_o = wbs_wmask_i;
        sram_din_o   = wbs_wdata_i;
      end
    end else if (gnt[GNT_DM]) begin
      sram_csb_o  = 1'b0;
      sram_web_o  = ~dm_we_i;
      sram_addr_o = dm_addr_i;
      if (dm_we_i) begin
        sram_wmask_o = dm_wmask_i;
        sram_din_o   = dm_wdata_i;
      end
    end else if (gnt[GNT_IF]) begin
      sram_csb_o  = 1'b0;
      sram_addr_o = if_addr_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      starve_cnt <= '0;
      rr_last_if <= 1'b1;
      rd_owner   <= REQ_NONE;
    end else begin
      // Counts only WB wins that left a core request waiting.
      if (!core_req || gnt[GNT_DM] || gnt[GNT_IF]) begin
        starve_cnt <= '0;
      end else if (gnt[GNT_WB] && !starve) begin
        starve_cnt <= starve_cnt + 8'd1;
      end

      if (gnt[GNT_DM]) begin
        rr_last_if <= 1'b0;
      end else if (gnt[GNT_IF]) begin
        rr_last_if <= 1'b1;
      end

      if (gnt[GNT_WB] && !wbs_we_i) begin
        rd_owner <= REQ_WB;
      end else if (gnt[GNT_DM] && !dm_we_i) begin
        rd_owner <= REQ_DM;
      end else if (gnt[GNT_IF]) begin
        rd_owner <= REQ_IF;
      end else begin
        rd_owner <= REQ_NONE;
      end
    end
  end

  assign wbs_rvalid_o = (rd_owner == REQ_WB) && !wb_rst_i;
  assign dm_rvalid_o  = (rd_owner == REQ_DM) && !wb_rst_i;
  assign if_rvalid_o  = (rd_owner == REQ_IF) && !wb_rst_i;

  assign wbs_rdata_o = wbs_rvalid_o ? sram_dout_i : '0;
  assign dm_rdata_o  = dm_rvalid_o  ? sram_dout_i : '0;
  assign if_rdata_o  = if_rvalid_o  ? sram_dout_i : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 512x32 SRAM.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_req, wbs_we, wbs_gnt, wbs_rvalid;
  logic [8:0]  wbs_addr;
  logic [31:0] wbs_wdata, wbs_rdata;
  logic [3:0]  wbs_wmask;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [8:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [3:0]  dm_wmask;
  logic        if_req, if_gnt, if_rvalid;
  logic [8:0]  if_addr;
  logic [31:0] if_rdata;
  logic        sram_csb, sram_web;
  logic [3:0]  sram_wmask;
  logic [8:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;

  logic        pre_en;
  logic [8:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:511];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_req_i    (wbs_req),
    .wbs_we_i     (wbs_we),
    .wbs_addr_i   (wbs_addr),
    .wbs_wdata_i  (wbs_wdata),
    .wbs_wmask_i  (wbs_wmask),
    .wbs_gnt_o    (wbs_gnt),
    .wbs_rvalid_o (wbs_rvalid),
    .wbs_rdata_o  (wbs_rdata),
    .dm_req_i     (dm_req),
    .dm_we_i      (dm_we),
    .dm_addr_i    (dm_addr),
    .dm_wdata_i   (dm_wdata),
    .dm_wmask_i   (dm_wmask),
    .dm_gnt_o     (dm_gnt),
    .dm_rvalid_o  (dm_rvalid),
    .dm_rdata_o   (dm_rdata),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_gnt_o     (if_gnt),
    .if_rvalid_o  (if_rvalid),
    .if_rdata_o   (if_rdata),
    .sram_csb_o   (sram_csb),
    .sram_web_o   (sram_web),
    .sram_wmask_o (sram_wmask),
    .sram_addr_o  (sram_addr),
    .sram_din_o   (sram_din),
    .sram_dout_i  (sram_dout)
  );

  // Behavioural SRAM: byte-masked writes, one-cycle read latency, bench preload port.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
        end
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    wbs_req = 0; wbs_we = 0; wbs_addr = '0; wbs_wdata = '0; wbs_wmask = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wmask = '0;
    if_req = 0; if_addr = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pre_en = 1; pre_addr = a; pre_data = d;
    next_cycle();
    pre_en = 0;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst = 1;
    wbs_req = 1; dm_req = 1; if_req = 1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({wbs_gnt, dm_gnt, if_gnt, wbs_rvalid, dm_rvalid, if_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_gnt_rvalid: got %b want 000000",
               {wbs_gnt, dm_gnt, if_gnt, wbs_rvalid, dm_rvalid, if_rvalid});
    end
    checks++;
    if ({sram_csb, sram_web, sram_wmask, sram_addr, sram_din} !== {2'b11, 4'h0, 9'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_sram: csb=%b web=%b wmask=%h addr=%h din=%h want 1 1 0 0 0",
               sram_csb, sram_web, sram_wmask, sram_addr, sram_din);
    end
    clear_reqs();
    next_cycle();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({sram_csb, wbs_gnt, dm_gnt, if_gnt} !== 4'b1000) begin
      errors++;
      $display("FAIL idle: csb,gnts=%b want 1000", {sram_csb, wbs_gnt, dm_gnt, if_gnt});
    end
    next_cycle();
  endtask

  task automatic test_if_read();
    do_reset();
    preload(9'h010, 32'hDEADBEEF);
    if_req = 1; if_addr = 9'h010;
    @(negedge clk);
    checks++;
    if ({if_gnt, dm_gnt, wbs_gnt, sram_csb, sram_web, sram_addr} !== {3'b100, 2'b01, 9'h010}) begin
      errors++;
      $display("FAIL if_read_grant: gnt(if,dm,wb)=%b csb=%b web=%b addr=%h want 100 0 1 010",
               {if_gnt, dm_gnt, wbs_gnt}, sram_csb, sram_web, sram_addr);
    end
    next_cycle();
    if_req = 0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL if_read_data: rvalid=%b rdata=%h want 1 deadbeef", if_rvalid, if_rdata);
    end
    checks++;
    if ({wbs_rvalid, dm_rvalid, wbs_rdata, dm_rdata} !== {2'b00, 64'h0}) begin
      errors++;
      $display("FAIL if_read_others: wb rv=%b dm rv=%b wb rd=%h dm rd=%h want 0 0 0 0",
               wbs_rvalid, dm_rvalid, wbs_rdata, dm_rdata);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    do_reset();
    dm_req = 1; dm_addr = 9'h001; if_req = 1; if_addr = 9'h002;
    for (int c = 0; c < 6; c++) begin
      exp = (c % 2 == 0) ? 3'b010 : 3'b100;  // {if, dm, wb}
      @(negedge clk);
      checks++;
      if ({if_gnt, dm_gnt, wbs_gnt} !== exp) begin
        errors++;
        $display("FAIL rr_cycle%0d: gnt(if,dm,wb)=%b want %b", c, {if_gnt, dm_gnt, wbs_gnt}, exp);
      end
      next_cycle();
    end
    clear_reqs();
  endtask

  task automatic test_starvation();
    logic [2:0] exp;
    do_reset();
    wbs_req = 1; wbs_we = 1; wbs_addr = 9'h100; wbs_wdata = 32'hCAFE0000; wbs_wmask = 4'hF;
    dm_req = 1; dm_addr = 9'h005;
    for (int c = 0; c < 18; c++) begin
      exp = (c == 8 || c == 17) ? 3'b010 : 3'b001;
      @(negedge clk);
      checks++;
      if ({if_gnt, dm_gnt, wbs_gnt} !== exp) begin
        errors++;
        $display("FAIL starve_cycle%0d: gnt(if,dm,wb)=%b want %b", c,
                 {if_gnt, dm_gnt, wbs_gnt}, exp);
      end
      if (c == 9) begin
        checks++;
        if (dut.starve_cnt !== 8'd0) begin
          errors++;
          $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt);
        end
      end
      next_cycle();
    end
    clear_reqs();
  endtask

  task automatic test_write_mask();
    do_reset();
    preload(9'h1FF, 32'hAABBCCDD);
    wbs_req = 1; wbs_we = 1; wbs_addr = 9'h1FF; wbs_wdata = 32'h12345678; wbs_wmask = 4'b0011;
    @(negedge clk);
    checks++;
    if ({wbs_gnt, sram_csb, sram_web, sram_wmask, sram_addr, sram_din} !==
        {3'b100, 4'b0011, 9'h1FF, 32'h12345678}) begin
      errors++;
      $display("FAIL wr_cycle: gnt=%b csb=%b web=%b wmask=%b addr=%h din=%h want 1 0 0 0011 1ff 12345678",
               wbs_gnt, sram_csb, sram_web, sram_wmask, sram_addr, sram_din);
    end
    next_cycle();
    clear_reqs();
    dm_req = 1; dm_addr = 9'h1FF;
    @(negedge clk);
    checks++;
    if ({dm_gnt, sram_web, wbs_rvalid} !== 3'b110) begin
      errors++;
      $display("FAIL wr_then_rd: dm_gnt=%b web=%b wbs_rvalid=%b want 1 1 0", dm_gnt, sram_web,
               wbs_rvalid);
    end
    next_cycle();
    clear_reqs();
    // A zero-mask write must still be accepted but leave the word alone.
    wbs_req = 1; wbs_we = 1; wbs_addr = 9'h1FF; wbs_wdata = 32'hFFFFFFFF; wbs_wmask = 4'b0000;
    @(negedge clk);
    checks++;
    if ({dm_rvalid, dm_rdata} !== {1'b1, 32'hAABB5678}) begin
      errors++;
      $display("FAIL merged_read: rvalid=%b rdata=%h want 1 aabb5678", dm_rvalid, dm_rdata);
    end
    checks++;
    if ({wbs_gnt, sram_web, sram_wmask} !== {2'b10, 4'b0000}) begin
      errors++;
      $display("FAIL zero_mask_grant: gnt=%b web=%b wmask=%b want 1 0 0000", wbs_gnt, sram_web,
               sram_wmask);
    end
    next_cycle();
    clear_reqs();
    if_req = 1; if_addr = 9'h1FF;
    next_cycle();
    clear_reqs();
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hAABB5678}) begin
      errors++;
      $display("FAIL zero_mask_keep: rvalid=%b rdata=%h want 1 aabb5678", if_rvalid, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    preload(9'h020, 32'h11111111);
    preload(9'h021, 32'h22222222);
    wbs_req = 1; wbs_addr = 9'h020;
    @(negedge clk);
    checks++;
    if ({wbs_gnt, sram_addr} !== {1'b1, 9'h020}) begin
      errors++;
      $display("FAIL b2b_wb_gnt: gnt=%b addr=%h want 1 020", wbs_gnt, sram_addr);
    end
    next_cycle();
    clear_reqs();
    if_req = 1; if_addr = 9'h021;
    @(negedge clk);
    checks++;
    if ({if_gnt, sram_addr, wbs_rvalid, wbs_rdata} !== {1'b1, 9'h021, 1'b1, 32'h11111111}) begin
      errors++;
      $display("FAIL b2b_overlap: if_gnt=%b addr=%h wb_rv=%b wb_rd=%h want 1 021 1 11111111",
               if_gnt, sram_addr, wbs_rvalid, wbs_rdata);
    end
    next_cycle();
    clear_reqs();
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata, wbs_rvalid} !== {1'b1, 32'h22222222, 1'b0}) begin
      errors++;
      $display("FAIL b2b_if_data: if_rv=%b if_rd=%h wb_rv=%b want 1 22222222 0",
               if_rvalid, if_rdata, wbs_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dm_req = 1; dm_addr = 9'h1FF;
    @(negedge clk);
    checks++;
    if (dm_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt: dm_gnt=%b want 1", dm_gnt);
    end
    next_cycle();
    clear_reqs();
    rst = 1;
    @(negedge clk);
    checks++;
    if ({dm_rvalid, dm_rdata} !== 33'h0) begin
      errors++;
      $display("FAIL rstmid_drop: dm_rvalid=%b dm_rdata=%h want 0 0", dm_rvalid, dm_rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({sram_csb, sram_web, sram_wmask, sram_addr, sram_din, dm_rvalid} !==
        {2'b11, 4'h0, 9'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_outputs: csb=%b web=%b wmask=%h addr=%h din=%h dm_rv=%b want 1 1 0 0 0 0",
               sram_csb, sram_web, sram_wmask, sram_addr, sram_din, dm_rvalid);
    end
    next_cycle();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({wbs_rvalid, dm_rvalid, if_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_owner: rvalids=%b want 000", {wbs_rvalid, dm_rvalid, if_rvalid});
    end
    next_cycle();
  endtask

  initial begin
    pre_en = 0; pre_addr = '0; pre_data = '0;
    rst = 1;
    clear_reqs();
    test_reset();
    test_if_read();
    test_round_robin();
    test_starvation();
    test_write_mask();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
